// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem_arbiter block.
// Optional feature macro used by the top: DMEM_ARB_ALIGN_CHECK_EN.
package dmem_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_t;

    typedef logic req_id_t;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the requester that did
// not win last time is chosen; a lone requester always wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  req_id_t            last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            gnt_id
);

    always_comb begin
        gnt_id = 1'b0;
        gnt    = '0;
        if (req_valid == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req_valid[1]) begin
            gnt_id = 1'b1;
        end
        if (|req_valid) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer in front of a single-port data memory.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject word-misaligned requests with rspErr.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_REQ-1:0]    reqValid,
    input  logic [NUM_REQ-1:0]    reqWrite,
    input  logic [ADDR_W-1:0]     reqAddr   [0:NUM_REQ-1],
    input  logic [DATA_W-1:0]     reqWrData [0:NUM_REQ-1],
    output logic [NUM_REQ-1:0]    reqReady,
    output logic [NUM_REQ-1:0]    rspValid,
    output logic [DATA_W-1:0]     rspData,
    output logic                  rspErr,
    output logic [ADDR_W-1:0]     memAddress,
    output logic [DATA_W-1:0]     memWrData,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [DATA_W-1:0]     memReadData
);

    localparam logic [1:0] CNT_INIT = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

    arb_state_t          state_q, state_d;
    req_id_t             last_grant_q, last_grant_d;
    req_id_t             id_q, id_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0]  gnt;
    req_id_t             gnt_id;
    logic                accept;
    logic                req_misaligned;

    rr_arb2 u_rr_arb2 (
        .req_valid  (reqValid),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign req_misaligned = is_misaligned(reqAddr[gnt_id]);
`else
    assign req_misaligned = 1'b0;
`endif

    // Gating with resetN keeps reqReady low while reset is held.
    assign accept   = (state_q == IDLE) && resetN && (|reqValid);
    assign reqReady = accept ? gnt : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        write_d      = write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = gnt_id;
                    id_d         = gnt_id;
                    write_d      = reqWrite[gnt_id];
                    err_d        = req_misaligned;
                    if (req_misaligned) begin
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        addr_d  = reqAddr[gnt_id];
                        wdata_d = reqWrData[gnt_id];
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    rsp_data_d = '0;
                    state_d    = RESP;
                end else if (RD_LATENCY == 0) begin
                    rsp_data_d = memReadData;
                    state_d    = RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    rsp_data_d = memReadData;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 2'd0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            write_q      <= write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Strobes decode straight from the state flop so an async reset drops them at once.
    assign memWrite   = (state_q == ACCESS) &&  write_q;
    assign memRead    = (state_q == ACCESS) && !write_q;
    assign memAddress = addr_q;
    assign memWrData  = wdata_q;
    assign rspData    = rsp_data_q;
    assign rspErr     = (state_q == RESP) && err_q;

    always_comb begin
        rspValid = '0;
        if (state_q == RESP) begin
            rspValid[id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (RD_LATENCY = 1) with a small
// registered-read memory model standing in for dataMemory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        resetN;
    logic [1:0]  reqValid, reqWrite, reqReady, rspValid;
    logic [31:0] reqAddr [0:1];
    logic [31:0] reqWrData [0:1];
    logic [31:0] rspData, memAddress, memWrData, memReadData;
    logic        rspErr, memWrite, memRead;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:63];
    logic [31:0] rd_q;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWrite) mem[memAddress[7:2]] <= memWrData;
        if (memRead)  rd_q <= mem[memAddress[7:2]];
    end
    assign memReadData = rd_q;

    dmem_arbiter #(.RD_LATENCY(1)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .reqValid    (reqValid),
        .reqWrite    (reqWrite),
        .reqAddr     (reqAddr),
        .reqWrData   (reqWrData),
        .reqReady    (reqReady),
        .rspValid    (rspValid),
        .rspData     (rspData),
        .rspErr      (rspErr),
        .memAddress  (memAddress),
        .memWrData   (memWrData),
        .memWrite    (memWrite),
        .memRead     (memRead),
        .memReadData (memReadData)
    );

    task automatic test_reset();
        resetN = 1'b0;
        reqValid = 2'b01; reqWrite = 2'b00;
        reqAddr[0] = 32'h0; reqAddr[1] = 32'h0;
        reqWrData[0] = 32'h0; reqWrData[1] = 32'h0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (reqReady !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", reqReady); end
        checks++; if (rspValid !== 2'b00) begin errors++; $display("FAIL rst_rspvalid: got %b want 00", rspValid); end
        checks++; if (rspData !== 32'h0 || rspErr !== 1'b0) begin errors++; $display("FAIL rst_rsp: got %h/%b want 0/0", rspData, rspErr); end
        checks++; if (memAddress !== 32'h0 || memWrData !== 32'h0) begin errors++; $display("FAIL rst_membus: got %h/%h want 0/0", memAddress, memWrData); end
        checks++; if (memWrite !== 1'b0 || memRead !== 1'b0) begin errors++; $display("FAIL rst_strobes: got %b%b want 00", memWrite, memRead); end
        @(negedge clk);
        resetN = 1'b1;
        reqValid = 2'b00;
    endtask

    task automatic test_write_read();
        logic [1:0]  oh;
        int          ids [2] = '{1, 0};
        logic [31:0] adr [2] = '{32'h8, 32'h4};
        logic [31:0] dat [2] = '{32'h88888888, 32'h44444444};
        @(negedge clk);
        reqValid = 2'b01; reqWrite = 2'b01; reqAddr[0] = 32'h0; reqWrData[0] = 32'h10101010;
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b want 01", reqReady); end
        @(negedge clk); reqValid = 2'b00; #1;
        checks++; if (memWrite !== 1'b1 || memRead !== 1'b0) begin errors++; $display("FAIL wr_strobe: got wr=%b rd=%b want 1/0", memWrite, memRead); end
        checks++; if (memAddress !== 32'h0 || memWrData !== 32'h10101010) begin errors++; $display("FAIL wr_bus: got %h/%h want 0/10101010", memAddress, memWrData); end
        @(negedge clk); #1;
        checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL wr_strobe_len: got %b want 0", memWrite); end
        checks++; if (rspValid !== 2'b01 || rspData !== 32'h0) begin errors++; $display("FAIL wr_rsp: got %b/%h want 01/0", rspValid, rspData); end
        @(negedge clk);
        reqValid = 2'b01; reqWrite = 2'b00;
        #1;
        checks++; if (reqReady !== 2'b01 || rspValid !== 2'b00) begin errors++; $display("FAIL rd_ready: got %b/%b want 01/00", reqReady, rspValid); end
        @(negedge clk); reqValid = 2'b00; #1;
        checks++; if (memRead !== 1'b1 || memWrite !== 1'b0) begin errors++; $display("FAIL rd_strobe: got rd=%b wr=%b want 1/0", memRead, memWrite); end
        @(negedge clk); #1;
        checks++; if (memRead !== 1'b0 || rspValid !== 2'b00) begin errors++; $display("FAIL rd_wait: got rd=%b rsp=%b want 0/00", memRead, rspValid); end
        @(negedge clk); #1;
        checks++; if (rspValid !== 2'b01 || rspData !== 32'h10101010) begin errors++; $display("FAIL rd_rsp: got %b/%h want 01/10101010", rspValid, rspData); end
        for (int k = 0; k < 2; k++) begin
            oh = 2'b01 << ids[k];
            @(negedge clk);
            reqValid = oh; reqWrite = oh; reqAddr[ids[k]] = adr[k]; reqWrData[ids[k]] = dat[k];
            #1;
            checks++; if (reqReady !== oh) begin errors++; $display("FAIL pre_ready%0d: got %b want %b", k, reqReady, oh); end
            @(negedge clk); reqValid = 2'b00; #1;
            checks++; if (memWrite !== 1'b1 || memAddress !== adr[k]) begin errors++; $display("FAIL pre_write%0d: got %b/%h want 1/%h", k, memWrite, memAddress, adr[k]); end
            @(negedge clk); #1;
            checks++; if (rspValid !== oh) begin errors++; $display("FAIL pre_rsp%0d: got %b want %b", k, rspValid, oh); end
        end
    endtask

    task automatic test_reset_during_wait();
        @(negedge clk);
        reqValid = 2'b01; reqWrite = 2'b00; reqAddr[0] = 32'h4;
        @(negedge clk); reqValid = 2'b00;
        @(negedge clk); #1;
        resetN = 1'b0; reqValid = 2'b01;
        #1;
        checks++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin errors++; $display("FAIL rstw_strobes: got rd=%b wr=%b want 0/0", memRead, memWrite); end
        checks++; if (rspValid !== 2'b00) begin errors++; $display("FAIL rstw_rsp: got %b want 00", rspValid); end
        @(negedge clk); #1;
        checks++; if (rspValid !== 2'b00 || reqReady !== 2'b00) begin errors++; $display("FAIL rstw_hold: got rsp=%b rdy=%b want 00/00", rspValid, reqReady); end
        @(negedge clk);
        resetN = 1'b1;
        reqValid = 2'b01; reqWrite = 2'b01; reqAddr[0] = 32'h30; reqWrData[0] = 32'h33333333;
        @(negedge clk); reqValid = 2'b00; #1;
        checks++; if (memWrite !== 1'b1) begin errors++; $display("FAIL rsta_pre: got %b want 1", memWrite); end
        resetN = 1'b0;
        #1;
        checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL rsta_async: got %b want 0", memWrite); end
        @(negedge clk); resetN = 1'b1;
        @(negedge clk); #1;
        checks++; if (rspValid !== 2'b00) begin errors++; $display("FAIL rsta_norsp: got %b want 00", rspValid); end
        reqValid = 2'b10; reqWrite = 2'b00; reqAddr[1] = 32'h8;
        #1;
        checks++; if (reqReady !== 2'b10) begin errors++; $display("FAIL post_ready: got %b want 10", reqReady); end
        @(negedge clk); reqValid = 2'b00; #1;
        checks++; if (memRead !== 1'b1 || memAddress !== 32'h8) begin errors++; $display("FAIL post_strobe: got %b/%h want 1/8", memRead, memAddress); end
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (rspValid !== 2'b10 || rspData !== 32'h88888888) begin errors++; $display("FAIL post_rsp: got %b/%h want 10/88888888", rspValid, rspData); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  oh;
        logic [31:0] ea, ed;
        reqValid = 2'b11; reqWrite = 2'b00; reqAddr[0] = 32'h4; reqAddr[1] = 32'h8;
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            ea = (k % 2 == 0) ? 32'h4 : 32'h8;
            ed = (k % 2 == 0) ? 32'h44444444 : 32'h88888888;
            @(negedge clk); #1;
            checks++; if (reqReady !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, reqReady, oh); end
            @(negedge clk); #1;
            checks++; if (memRead !== 1'b1 || memAddress !== ea || reqReady !== 2'b00) begin errors++; $display("FAIL rr_access%0d: got %b/%h/%b want 1/%h/00", k, memRead, memAddress, reqReady, ea); end
            @(negedge clk);
            @(negedge clk); #1;
            checks++; if (rspValid !== oh || rspData !== ed) begin errors++; $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", k, rspValid, rspData, oh, ed); end
        end
        @(negedge clk);
        reqValid = 2'b00;
    endtask

    task automatic test_blocked_write();
        @(negedge clk);
        reqValid = 2'b01; reqWrite = 2'b00; reqAddr[0] = 32'h0;
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("FAIL blk_ready0: got %b want 01", reqReady); end
        @(negedge clk);
        reqValid = 2'b10; reqWrite = 2'b10; reqAddr[1] = 32'h20; reqWrData[1] = 32'hDEADBEEF;
        #1;
        checks++; if (reqReady !== 2'b00) begin errors++; $display("FAIL blk_access: got %b want 00", reqReady); end
        @(negedge clk); #1;
        checks++; if (reqReady !== 2'b00) begin errors++; $display("FAIL blk_wait: got %b want 00", reqReady); end
        @(negedge clk); #1;
        checks++; if (reqReady !== 2'b00 || rspValid !== 2'b01 || rspData !== 32'h10101010) begin errors++; $display("FAIL blk_resp: got %b/%b/%h want 00/01/10101010", reqReady, rspValid, rspData); end
        @(negedge clk); #1;
        checks++; if (reqReady !== 2'b10) begin errors++; $display("FAIL blk_ready1: got %b want 10", reqReady); end
        @(negedge clk); reqValid = 2'b00; #1;
        checks++; if (memWrite !== 1'b1 || memAddress !== 32'h20 || memWrData !== 32'hDEADBEEF) begin errors++; $display("FAIL blk_write: got %b/%h/%h want 1/20/deadbeef", memWrite, memAddress, memWrData); end
        @(negedge clk); #1;
        checks++; if (rspValid !== 2'b10 || rspData !== 32'h0) begin errors++; $display("FAIL blk_wrsp: got %b/%h want 10/0", rspValid, rspData); end
        checks++; if (mem[8] !== 32'hDEADBEEF) begin errors++; $display("FAIL blk_mem: got %h want deadbeef", mem[8]); end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        reqValid = 2'b01; reqWrite = 2'b00; reqAddr[0] = 32'h6;
        #1;
        checks++; if (reqReady !== 2'b01) begin errors++; $display("FAIL mis_ready: got %b want 01", reqReady); end
        @(negedge clk); reqValid = 2'b00; #1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        checks++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin errors++; $display("FAIL mis_nostrobe: got rd=%b wr=%b want 0/0", memRead, memWrite); end
        checks++; if (rspValid !== 2'b01 || rspErr !== 1'b1 || rspData !== 32'h0) begin errors++; $display("FAIL mis_rsp: got %b/%b/%h want 01/1/0", rspValid, rspErr, rspData); end
        checks++; if (memAddress !== 32'h20) begin errors++; $display("FAIL mis_addr_hold: got %h want 20", memAddress); end
        @(negedge clk); #1;
        checks++; if (rspValid !== 2'b00) begin errors++; $display("FAIL mis_once: got %b want 00", rspValid); end
`else
        checks++; if (memRead !== 1'b1 || memAddress !== 32'h6) begin errors++; $display("FAIL mis_fwd: got %b/%h want 1/6", memRead, memAddress); end
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (rspValid !== 2'b01 || rspErr !== 1'b0 || rspData !== 32'h44444444) begin errors++; $display("FAIL mis_rsp: got %b/%b/%h want 01/0/44444444", rspValid, rspErr, rspData); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reset_during_wait();
        test_round_robin();
        test_blocked_write();
        test_misaligned();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
